// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and widths for the unified-memory arbiter
package mem_arb_pkg;

    localparam int LINE_ADDR_W = 14;
    localparam int LINE_W      = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory signal bundle for mem_arbiter
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic                   i_req;
    logic [LINE_ADDR_W-1:0] i_addr;
    logic                   i_done;

    logic                   d_req;
    logic                   d_wr;
    logic [LINE_ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0]      d_wdata;
    logic                   d_done;

    logic [LINE_W-1:0]      rdata;
    logic                   err;
    logic                   busy;

    logic [LINE_ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0]      mem_wdata;
    logic                   mem_re;
    logic                   mem_we;
    logic [LINE_W-1:0]      mem_rdata;
    logic                   mem_rdy;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_rdy,
        output i_done, d_done, rdata, err, busy, mem_addr, mem_wdata, mem_re, mem_we
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_rdy,
        input  i_done, d_done, rdata, err, busy, mem_addr, mem_wdata, mem_re, mem_we
    );

endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache miss arbiter and access sequencer for the unified memory
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    state_t                 state;
    state_t                 state_nxt;
    owner_t                 last;
    owner_t                 owner;
    owner_t                 win;
    logic                   is_wr;
    logic                   any_req;
    logic                   timeout;
    logic [CNT_W-1:0]       wait_cnt;
    logic                   err_q;
    logic [LINE_W-1:0]      rdata_q;
    logic [LINE_ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0]      wdata_q;
    logic                   re_q;
    logic                   we_q;

    // On a tie the side that was not granted last wins.
    function automatic owner_t pick(input logic i_req, input logic d_req, input owner_t last_own);
        return (d_req && (!i_req || last_own == OWN_I)) ? OWN_D : OWN_I;
    endfunction

    always_comb begin
        state_nxt = state;
        any_req   = bus.i_req | bus.d_req;
        win       = pick(bus.i_req, bus.d_req, last);
        timeout   = (wait_cnt == CNT_W'(WAIT_MAX - 1));
        case (state)
            ST_IDLE:  if (any_req) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (bus.mem_rdy || timeout) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last     <= OWN_I;
            owner    <= OWN_I;
            is_wr    <= 1'b0;
            wait_cnt <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            re_q     <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        last    <= win;
                        owner   <= win;
                        is_wr   <= (win == OWN_D) && bus.d_wr;
                        addr_q  <= (win == OWN_D) ? bus.d_addr : bus.i_addr;
                        wdata_q <= ((win == OWN_D) && bus.d_wr) ? bus.d_wdata : '0;
                        re_q    <= !((win == OWN_D) && bus.d_wr);
                        we_q    <= (win == OWN_D) && bus.d_wr;
                    end
                end
                ST_ISSUE: begin
                    // The memory pulls rdy low combinationally here, so it is not looked at.
                    re_q     <= 1'b0;
                    we_q     <= 1'b0;
                    wait_cnt <= '0;
                end
                ST_WAIT: begin
                    if (bus.mem_rdy) begin
                        if (!is_wr) rdata_q <= bus.mem_rdata;
                    end else if (timeout) begin
                        err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    err_q <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.i_done    = (state == ST_DONE) && (owner == OWN_I);
    assign bus.d_done    = (state == ST_DONE) && (owner == OWN_D);
    assign bus.err       = err_q;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_re    = re_q;
    assign bus.mem_we    = we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a transaction-level model
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int WAIT_MAX = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mem_arbiter_if bus();

    mem_arbiter #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [63:0] preload_val(input logic [13:0] a);
        return {50'h0, a} ^ 64'hA5A5_5A5A_0F0F_F0F0;
    endfunction

    // memory stub: 4-clock access, rdy low from the command cycle until the data cycle
    bit          stuck = 1'b0;
    logic [63:0] smem [0:255];
    bit          swr  [0:255];
    logic [13:0] lat_addr;
    int          mcnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt <= 0;
        end else if (bus.mem_re || bus.mem_we) begin
            mcnt     <= 2;
            lat_addr <= bus.mem_addr;
            if (bus.mem_we && !stuck) begin
                smem[bus.mem_addr[7:0]] <= bus.mem_wdata;
                swr[bus.mem_addr[7:0]]  <= 1'b1;
            end
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
        end
    end

    assign bus.mem_rdy   = !stuck && !bus.mem_re && !bus.mem_we && (mcnt == 0);
    assign bus.mem_rdata = swr[lat_addr[7:0]] ? smem[lat_addr[7:0]] : preload_val(lat_addr);

    // transaction model: an access granted at cycle g issues at g+1 and completes at g+dn
    int          m_cyc, m_g, m_dn, m_rel;
    bit          m_d, m_wr, m_last_d, m_to;
    logic [13:0] m_addr;
    logic [63:0] m_wdata, m_rdata;
    logic [63:0] m_mem [int];
    bit          e_busy, e_re, e_we, e_done, e_err;

    initial begin
        m_cyc = 0; m_g = -1; m_dn = 0; m_last_d = 0;
        m_d = 0; m_wr = 0; m_to = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
        forever begin
            @(negedge clk);
            m_cyc++;
            if (!rst_n) begin
                m_g = -1; m_last_d = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
                e_busy = 0; e_re = 0; e_we = 0; e_done = 0; e_err = 0;
            end else begin
                m_rel  = (m_g < 0) ? -1 : m_cyc - m_g;
                e_busy = (m_g >= 0) && (m_rel >= 1);
                e_re   = (m_rel == 1) && !m_wr;
                e_we   = (m_rel == 1) && m_wr;
                e_done = (m_g >= 0) && (m_rel == m_dn);
                e_err  = e_done && m_to;
                if (e_done && !m_wr && !m_to)
                    m_rdata = m_mem.exists(int'(m_addr)) ? m_mem[int'(m_addr)] : preload_val(m_addr);
            end
            chk("busy",      bus.busy,      e_busy);
            chk("mem_re",    bus.mem_re,    e_re);
            chk("mem_we",    bus.mem_we,    e_we);
            chk("re_we_excl", bus.mem_re & bus.mem_we, 0);
            chk("i_done",    bus.i_done,    e_done && !m_d);
            chk("d_done",    bus.d_done,    e_done && m_d);
            chk("err",       bus.err,       e_err);
            chk("rdata",     bus.rdata,     m_rdata);
            chk("mem_addr",  bus.mem_addr,  m_addr);
            chk("mem_wdata", bus.mem_wdata, m_wdata);
            if (rst_n) begin
                if (e_done) begin
                    m_g = -1;
                end else if (m_g < 0 && (bus.i_req || bus.d_req)) begin
                    if (bus.i_req && bus.d_req) m_d = !m_last_d;
                    else                        m_d = bus.d_req;
                    m_last_d = m_d;
                    m_wr     = m_d && bus.d_wr;
                    m_addr   = m_d ? bus.d_addr : bus.i_addr;
                    m_wdata  = m_wr ? bus.d_wdata : 64'h0;
                    m_to     = stuck;
                    m_dn     = m_to ? 2 + WAIT_MAX : 5;
                    m_g      = m_cyc;
                    if (m_wr && !m_to) m_mem[int'(m_addr)] = m_wdata;
                end
            end
        end
    end

    int n_re = 0;
    int n_we = 0;
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (bus.mem_re) n_re++;
            if (bus.mem_we) n_we++;
        end
    end

    task automatic request(input bit is_d, input bit wr, input logic [13:0] a, input logic [63:0] wd,
                           output int lat, output logic [63:0] rd, output logic e);
        @(posedge clk); #1;
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_wr = wr; bus.d_addr = a; bus.d_wdata = wd;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = a;
        end
        lat = -1; rd = '0; e = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (is_d ? bus.d_done : bus.i_done) begin
                lat = k; rd = bus.rdata; e = bus.err;
                break;
            end
        end
        @(posedge clk); #1;
        if (is_d) bus.d_req = 1'b0;
        else      bus.i_req = 1'b0;
    endtask

    int          lat, lat_d, lat_i, re0, we0;
    logic [63:0] rd, rd_d, rd_i, rd_before;
    logic        e, e_d, e_i;
    bit          own_q [$];
    int          cyc_q [$];

    initial begin
        bus.i_req = 0; bus.i_addr = '0;
        bus.d_req = 0; bus.d_wr = 0; bus.d_addr = '0; bus.d_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // simultaneous requests straight after reset: D first, then alternate
        @(posedge clk); #1;
        bus.i_req = 1; bus.i_addr = 14'h0030;
        bus.d_req = 1; bus.d_wr = 0; bus.d_addr = 14'h0031;
        for (int k = 0; k < 60 && own_q.size() < 4; k++) begin
            @(negedge clk);
            if (bus.d_done) begin own_q.push_back(1'b1); cyc_q.push_back(k); end
            if (bus.i_done) begin own_q.push_back(1'b0); cyc_q.push_back(k); end
        end
        @(posedge clk); #1;
        bus.i_req = 0; bus.d_req = 0;
        chk("tie_count", own_q.size(), 4);
        if (own_q.size() == 4) begin
            chk("tie_own0", own_q[0], 1);
            chk("tie_own1", own_q[1], 0);
            chk("tie_own2", own_q[2], 1);
            chk("tie_own3", own_q[3], 0);
            chk("tie_first_done", cyc_q[0], 5);
            chk("tie_gap1", cyc_q[1] - cyc_q[0], 6);
            chk("tie_gap2", cyc_q[2] - cyc_q[1], 6);
            chk("tie_gap3", cyc_q[3] - cyc_q[2], 6);
        end

        // lone I read
        re0 = n_re;
        request(0, 0, 14'h0010, '0, lat, rd, e);
        chk("i_lat", lat, 5);
        chk("i_rdata", rd, 64'hA5A5_5A5A_0F0F_F0E0);
        chk("i_re_pulses", n_re - re0, 1);

        // D write then read back
        we0 = n_we; re0 = n_re;
        request(1, 1, 14'h0020, 64'hDEAD_BEEF_0123_4567, lat, rd, e);
        chk("dw_lat", lat, 5);
        chk("dw_we_pulses", n_we - we0, 1);
        chk("dw_re_pulses", n_re - re0, 0);
        request(1, 0, 14'h0020, '0, lat, rd, e);
        chk("dr_lat", lat, 5);
        chk("dr_rdata", rd, 64'hDEAD_BEEF_0123_4567);

        // I request arrives while D is in WAIT
        fork
            request(1, 0, 14'h0040, '0, lat_d, rd_d, e_d);
            begin
                repeat (3) @(posedge clk);
                request(0, 0, 14'h0041, '0, lat_i, rd_i, e_i);
            end
        join
        chk("busy_d_lat", lat_d, 5);
        chk("busy_d_rdata", rd_d, 64'hA5A5_5A5A_0F0F_F0B0);
        chk("busy_i_lat", lat_i, 8);
        chk("busy_i_rdata", rd_i, 64'hA5A5_5A5A_0F0F_F0B1);

        // memory never answers: timeout with err, rdata untouched
        stuck = 1'b1;
        rd_before = bus.rdata;
        request(1, 0, 14'h0050, '0, lat, rd, e);
        stuck = 1'b0;
        chk("to_lat", lat, 2 + WAIT_MAX);
        chk("to_err", e, 1);
        chk("to_rdata", rd, rd_before);

        // reset during WAIT
        @(posedge clk); #1;
        bus.i_req = 1; bus.i_addr = 14'h0012;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0; bus.i_req = 0;
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_done", bus.i_done | bus.d_done, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (8) @(negedge clk);

        request(0, 0, 14'h0011, '0, lat, rd, e);
        chk("post_rst_lat", lat, 5);
        chk("post_rst_rdata", rd, 64'hA5A5_5A5A_0F0F_F0E1);
        chk("post_rst_err", e, 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
